// File: rtl/flush_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : flush_redirect_ctrl_if
// Description : Flush/redirect and instruction-bus bookkeeping signals shared
//               by cp0_reg, the fetch stage and flush_redirect_ctrl.
//               The slave modport is the controller's view; the master
//               modport is the environment's view (cp0, fetch, bus).
// Revision    : 1.0 - initial release
// ============================================================================
interface flush_redirect_ctrl_if;
  // Flush requests from cp0_reg
  logic        ex_flush;
  logic        eret_flush;
  logic [31:0] eret_pc;

  // SRAM-like instruction port activity
  logic        inst_req;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  // Controls back to the pipeline / fetch stage
  logic        pipe_flush;
  logic        fetch_stall;
  logic        discard_rdata;

  // Redirect handshake towards fetch
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  // Status
  logic        busy;
  logic        proto_err;

  modport slave (
    input  ex_flush,
    input  eret_flush,
    input  eret_pc,
    input  inst_req,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  redirect_ready,
    output pipe_flush,
    output fetch_stall,
    output discard_rdata,
    output redirect_valid,
    output redirect_pc,
    output busy,
    output proto_err
  );

  modport master (
    output ex_flush,
    output eret_flush,
    output eret_pc,
    output inst_req,
    output inst_addr_ok,
    output inst_data_ok,
    output redirect_ready,
    input  pipe_flush,
    input  fetch_stall,
    input  discard_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  busy,
    input  proto_err
  );
endinterface
`default_nettype wire

// File: rtl/flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flush_redirect_ctrl
// Description : Sequences the pipeline redirect after an exception or ERET.
//               Counts in-flight instruction requests, holds fetch off and
//               marks stale read data until the bus drains, then offers the
//               new PC to fetch over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module flush_redirect_ctrl #(
  parameter int          MAX_OUTST = 3,
  parameter logic [31:0] EX_ENTRY  = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  reset,
  flush_redirect_ctrl_if.slave  bus
);

  localparam int            CW      = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          cnt_err;
  logic [31:0]   target;
  logic          err_flag;
  logic          redirect_vld;
  logic          seq_stall;
  logic          seq_busy;

  logic          inc;
  logic          dec;
  logic          cnt_zero;
  logic          cnt_full;
  logic          flush_any;
  logic          flush_take;

  // --------------------------------------------------------------------------
  // Outstanding-request bookkeeping
  // --------------------------------------------------------------------------
  assign cnt_zero = (cnt == '0);
  assign cnt_full = (cnt == CNT_MAX);
  assign inc      = bus.inst_req & bus.inst_addr_ok;
  // A data beat with nothing outstanding is a protocol error, not a decrement.
  assign dec      = bus.inst_data_ok & ~cnt_zero;

  // Post-update counter value; saturates at both ends and flags violations.
  always_comb begin
    cnt_next = cnt;
    cnt_err  = 1'b0;
    if (inc && !dec) begin
      if (cnt_full) begin
        cnt_err = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (dec && !inc) begin
      cnt_next = cnt - CNT_ONE;
    end
    if (bus.inst_data_ok && cnt_zero) begin
      cnt_err = 1'b1;
    end
  end

  // Counter register and sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      err_flag <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_err) begin
        err_flag <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Flush acceptance: any flush starts a sequence from IDLE; once a sequence
  // is running only an exception can restart it (ERET is dropped).
  // --------------------------------------------------------------------------
  assign flush_any  = bus.ex_flush | bus.eret_flush;
  assign flush_take = (state == IDLE) ? flush_any : bus.ex_flush;

  // --------------------------------------------------------------------------
  // Sequencer: state, captured target and the registered handshake/stall
  // flags all move together so the outputs come straight from flops.
  // --------------------------------------------------------------------------
  // Redirect sequencing state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      target       <= 32'h0;
      redirect_vld <= 1'b0;
      seq_stall    <= 1'b0;
      seq_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_any) begin
            // Exception wins over a simultaneous ERET.
            target    <= bus.ex_flush ? EX_ENTRY : bus.eret_pc;
            seq_stall <= 1'b1;
            seq_busy  <= 1'b1;
            if (cnt_next == '0) begin
              state        <= REDIRECT;
              redirect_vld <= 1'b1;
            end else begin
              state        <= DRAIN;
              redirect_vld <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (bus.ex_flush) begin
            target <= EX_ENTRY;
          end
          // Requests accepted while draining are counted, so we leave only
          // once every stale beat (old and new) has been returned.
          if (cnt_next == '0) begin
            state        <= REDIRECT;
            redirect_vld <= 1'b1;
          end
        end

        REDIRECT: begin
          if (bus.ex_flush) begin
            // Restart: any handshake offered this cycle is cancelled.
            target <= EX_ENTRY;
            if (cnt_next != '0) begin
              state        <= DRAIN;
              redirect_vld <= 1'b0;
            end
          end else if (bus.redirect_ready) begin
            state        <= IDLE;
            redirect_vld <= 1'b0;
            seq_stall    <= 1'b0;
            seq_busy     <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          redirect_vld <= 1'b0;
          seq_stall    <= 1'b0;
          seq_busy     <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pipe_flush     = flush_take;
  assign bus.fetch_stall    = seq_stall | cnt_full;
  assign bus.discard_rdata  = (state == DRAIN) & bus.inst_data_ok & ~cnt_zero;
  assign bus.redirect_valid = redirect_vld;
  assign bus.redirect_pc    = target;
  assign bus.busy           = seq_busy;
  assign bus.proto_err      = err_flag;

endmodule
`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flush_redirect_ctrl
// Description : Directed bench for flush_redirect_ctrl. Stimulus pushes the
//               expected redirect PC when a flush is issued; a monitor pops
//               and compares on every redirect handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flush_redirect_ctrl;

  localparam logic [31:0] EXV = 32'hBFC00380;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  flush_redirect_ctrl_if bus ();

  flush_redirect_ctrl #(
    .MAX_OUTST (3),
    .EX_ENTRY  (EXV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted redirect must match the next expected PC.
  always @(negedge clk) begin
    if (!reset && bus.redirect_valid && bus.redirect_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: got pc %h expected none", bus.redirect_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.redirect_pc !== mon_exp) begin
          errors++;
          $display("FAIL redirect_pc: got %h expected %h", bus.redirect_pc, mon_exp);
        end
      end
    end
  end

  task automatic clr();
    bus.ex_flush       = 1'b0;
    bus.eret_flush     = 1'b0;
    bus.inst_req       = 1'b0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_pipe_flush"}, bus.pipe_flush, 1'b0);
    chk1({tag, "_fetch_stall"}, bus.fetch_stall, 1'b0);
    chk1({tag, "_discard"}, bus.discard_rdata, 1'b0);
    chk1({tag, "_rvalid"}, bus.redirect_valid, 1'b0);
    chk32({tag, "_rpc"}, bus.redirect_pc, 32'h0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_proto_err"}, bus.proto_err, 1'b0);
  endtask

  task automatic addr_beat();
    bus.inst_req     = 1'b1;
    bus.inst_addr_ok = 1'b1;
  endtask

  // Directed stimulus.
  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.eret_pc = 32'h0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();

    // 1: ERET with nothing outstanding.
    bus.eret_flush = 1'b1;
    bus.eret_pc    = 32'h80001234;
    exp_q.push_back(32'h80001234);
    @(negedge clk);
    chk1("t1_pipe_flush", bus.pipe_flush, 1'b1);
    chk1("t1_rvalid_early", bus.redirect_valid, 1'b0);
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t1_rvalid", bus.redirect_valid, 1'b1);
    chk32("t1_rpc", bus.redirect_pc, 32'h80001234);
    chk1("t1_busy", bus.busy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("t1_busy_after", bus.busy, 1'b0);
    chk1("t1_rvalid_after", bus.redirect_valid, 1'b0);
    next_cycle();

    // 2: exception with two outstanding requests.
    addr_beat();
    next_cycle();
    addr_beat();
    next_cycle();
    bus.ex_flush = 1'b1;
    exp_q.push_back(EXV);
    @(negedge clk);
    chk1("t2_pipe_flush", bus.pipe_flush, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      bus.inst_data_ok = (k == 3) || (k == 5);
      @(negedge clk);
      chk1("t2_stall", bus.fetch_stall, 1'b1);
      chk1("t2_discard", bus.discard_rdata, (k == 3) || (k == 5));
      chk1("t2_rvalid_low", bus.redirect_valid, 1'b0);
    end
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t2_rvalid", bus.redirect_valid, 1'b1);
    chk1("t2_stall_redirect", bus.fetch_stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("t2_busy_after", bus.busy, 1'b0);
    next_cycle();

    // 3: simultaneous exception and ERET; exception wins.
    bus.ex_flush   = 1'b1;
    bus.eret_flush = 1'b1;
    bus.eret_pc    = 32'h80000100;
    exp_q.push_back(EXV);
    @(negedge clk);
    chk1("t3_pipe_flush", bus.pipe_flush, 1'b1);
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t3_rvalid", bus.redirect_valid, 1'b1);
    chk32("t3_rpc", bus.redirect_pc, EXV);
    next_cycle();

    // 4: saturate the counter, then overflow it.
    addr_beat();
    next_cycle();
    addr_beat();
    next_cycle();
    addr_beat();
    @(negedge clk);
    chk1("t4_stall_cnt2", bus.fetch_stall, 1'b0);
    next_cycle();
    addr_beat();
    @(negedge clk);
    chk1("t4_stall_full", bus.fetch_stall, 1'b1);
    chk1("t4_err_before", bus.proto_err, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("t4_err_set", bus.proto_err, 1'b1);
    chk1("t4_stall_held", bus.fetch_stall, 1'b1);
    next_cycle();
    bus.ex_flush = 1'b1;
    exp_q.push_back(EXV);
    @(negedge clk);
    chk1("t4_pipe_flush", bus.pipe_flush, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      bus.inst_data_ok = 1'b1;
      @(negedge clk);
      chk1("t4_discard", bus.discard_rdata, 1'b1);
      chk1("t4_rvalid_low", bus.redirect_valid, 1'b0);
    end
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t4_rvalid", bus.redirect_valid, 1'b1);
    chk1("t4_err_sticky", bus.proto_err, 1'b1);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk1("t4_err_cleared", bus.proto_err, 1'b0);
    next_cycle();

    // 5: data beat with nothing outstanding.
    bus.inst_data_ok = 1'b1;
    @(negedge clk);
    chk1("t5_discard", bus.discard_rdata, 1'b0);
    next_cycle();
    bus.eret_flush = 1'b1;
    bus.eret_pc    = 32'h80000040;
    exp_q.push_back(32'h80000040);
    @(negedge clk);
    chk1("t5_err", bus.proto_err, 1'b1);
    chk1("t5_busy", bus.busy, 1'b0);
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t5_cnt_zero_rvalid", bus.redirect_valid, 1'b1);
    next_cycle();

    // 6a: reset while draining aborts the sequence.
    do_reset();
    addr_beat();
    next_cycle();
    addr_beat();
    next_cycle();
    bus.ex_flush = 1'b1;
    next_cycle();
    @(negedge clk);
    chk1("t6_busy_drain", bus.busy, 1'b1);
    chk1("t6_stall_drain", bus.fetch_stall, 1'b1);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk_all_zero("t6_reset");
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t6_no_redirect", bus.redirect_valid, 1'b0);
    next_cycle();

    // 6b: exception during an ERET redirect overrides the target.
    bus.eret_flush = 1'b1;
    bus.eret_pc    = 32'h80002000;
    next_cycle();
    @(negedge clk);
    chk1("t6b_rvalid", bus.redirect_valid, 1'b1);
    chk32("t6b_rpc_eret", bus.redirect_pc, 32'h80002000);
    next_cycle();
    bus.ex_flush = 1'b1;
    exp_q.push_back(EXV);
    @(negedge clk);
    chk1("t6b_pipe_flush", bus.pipe_flush, 1'b1);
    next_cycle();
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk1("t6b_rvalid2", bus.redirect_valid, 1'b1);
    chk32("t6b_rpc_ex", bus.redirect_pc, EXV);
    next_cycle();
    @(negedge clk);
    chk1("t6b_busy_after", bus.busy, 1'b0);
    next_cycle();

    chk32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
